cpu_multicycle: RTL and testbench

//  Parametrised multi-cycle successor of the single-cycle RV32 integer core.
//  One FSM walks FETCH/DECODE/EXEC/WB per instruction, behind a req/ack fetch handshake that tolerates wait states.

---
 rtl/cpu_mc_pkg.sv | 21 ++
 rtl/cpu_mc_regfile.sv | 33 +++
 rtl/cpu_multicycle.sv | 196 +++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
// Shared constants and enums for the multi-cycle RV32 core.
package cpu_mc_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SRA    = 3'b101;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MUL, S_WB} state_e;

    typedef enum logic [2:0] {ALU_AND, ALU_XOR, ALU_SLL, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SRA, ALU_NOP} alu_op_e;

endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file: async clear, two operand read ports, one debug read port, one write port; x0 reads as zero.
module cpu_mc_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] waddr_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [$clog2(NREGS)-1:0] raddr1_i,
    output logic [XLEN-1:0]          rdata1_o,
    input  logic [$clog2(NREGS)-1:0] raddr2_i,
    output logic [XLEN-1:0]          rdata2_o,
    input  logic [$clog2(NREGS)-1:0] dbg_raddr_i,
    output logic [XLEN-1:0]          dbg_rdata_o
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o    = (raddr1_i    == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o    = (raddr2_i    == '0) ? '0 : regs_q[raddr2_i];
    assign dbg_rdata_o = (dbg_raddr_i == '0) ? '0 : regs_q[dbg_raddr_i];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32 ALU-subset core: FETCH/DECODE/EXEC/WB FSM behind a req/ack fetch port.
// Define CPU_MC_ITER_MUL_EN to replace the combinational multiplier with an XLEN-cycle shift-add MUL state.
module cpu_multicycle
    import cpu_mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic                     imem_req_o,
    output logic [XLEN-1:0]          imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [31:0]              imem_instr_i,
    output logic                     retire_o,
    output logic                     illegal_o,
    output logic [XLEN-1:0]          pc_o,
    input  logic [$clog2(NREGS)-1:0] dbg_raddr_i,
    output logic [XLEN-1:0]          dbg_rdata_o
);

    localparam int AW = $clog2(NREGS);

    state_e          state_q;
    logic [XLEN-1:0] pc_q, a_q, b_q, imm_q, r_q;
    logic [31:0]     ir_q;
    logic            req_q, retire_q, illegal_q;

    logic [XLEN-1:0] rs1_data, rs2_data, imm_d, op2_d, alu_res_d;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic            use_imm_d;
    alu_op_e         alu_op_d;

`ifdef CPU_MC_ITER_MUL_EN
    localparam int CW = $clog2(XLEN);
    logic [XLEN-1:0] acc_q, mcand_q, mplier_q;
    logic [CW-1:0]   cnt_q;
`endif

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign imm_d  = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};

    always_comb begin
        alu_op_d  = ALU_NOP;
        use_imm_d = 1'b0;
        if (opcode == OP_RTYPE) begin
            case ({funct7, funct3})
                {F7_BASE,   F3_AND}: alu_op_d = ALU_AND;
                {F7_BASE,   F3_XOR}: alu_op_d = ALU_XOR;
                {F7_BASE,   F3_SLL}: alu_op_d = ALU_SLL;
                {F7_BASE,   F3_ADD}: alu_op_d = ALU_ADD;
                {F7_ALT,    F3_ADD}: alu_op_d = ALU_SUB;
                {F7_MULDIV, F3_ADD}: alu_op_d = ALU_MUL;
                default:             alu_op_d = ALU_NOP;
            endcase
        end else if (opcode == OP_ITYPE) begin
            use_imm_d = 1'b1;
            if (funct3 == F3_ADD)                            alu_op_d = ALU_ADD;
            else if ((funct3 == F3_SRA) && (funct7 == F7_ALT)) alu_op_d = ALU_SRA;
        end
    end

    assign op2_d = use_imm_d ? imm_q : b_q;

    always_comb begin
        alu_res_d = '0;
        case (alu_op_d)
            ALU_AND: alu_res_d = a_q & b_q;
            ALU_XOR: alu_res_d = a_q ^ b_q;
            ALU_SLL: alu_res_d = a_q << b_q[4:0];
            ALU_ADD: alu_res_d = a_q + op2_d;
            ALU_SUB: alu_res_d = a_q - b_q;
`ifndef CPU_MC_ITER_MUL_EN
            ALU_MUL: alu_res_d = a_q * b_q;
`endif
            ALU_SRA: alu_res_d = XLEN'($signed(a_q) >>> imm_q[4:0]);
            default: alu_res_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            r_q       <= '0;
            req_q     <= 1'b0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
`ifdef CPU_MC_ITER_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        ir_q    <= imem_instr_i;
                        req_q   <= 1'b0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rs1_data;
                    b_q     <= rs2_data;
                    imm_q   <= imm_d;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
`ifdef CPU_MC_ITER_MUL_EN
                    if (alu_op_d == ALU_MUL) begin
                        acc_q    <= '0;
                        mcand_q  <= a_q;
                        mplier_q <= b_q;
                        cnt_q    <= '0;
                        state_q  <= S_MUL;
                    end else
`endif
                    begin
                        r_q       <= alu_res_d;
                        retire_q  <= 1'b1;
                        illegal_q <= (alu_op_d == ALU_NOP);
                        state_q   <= S_WB;
                    end
                end
`ifdef CPU_MC_ITER_MUL_EN
                // One partial product per cycle; the last one is folded straight into R.
                S_MUL: begin
                    if (cnt_q == CW'(XLEN-1)) begin
                        r_q      <= acc_q + (mplier_q[0] ? mcand_q : '0);
                        retire_q <= 1'b1;
                        state_q  <= S_WB;
                    end else begin
                        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
`endif
                S_WB: begin
                    pc_q <= pc_q + XLEN'(4);
                    if (start_i) begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    cpu_mc_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .we_i        ((state_q == S_WB) && !illegal_q),
        .waddr_i     (ir_q[7 +: AW]),
        .wdata_i     (r_q),
        .raddr1_i    (ir_q[15 +: AW]),
        .rdata1_o    (rs1_data),
        .raddr2_i    (ir_q[20 +: AW]),
        .rdata2_o    (rs2_data),
        .dbg_raddr_i (dbg_raddr_i),
        .dbg_rdata_o (dbg_rdata_o)
    );

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign retire_o    = retire_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle with a zero/parametrised wait-state instruction memory model.
module tb_cpu_multicycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ack_en = 1'b1;
    logic        imem_req, imem_ack, retire, illegal;
    logic [31:0] imem_addr, instr, pc, dbg_rdata;
    logic [4:0]  dbg_raddr = '0;

    logic [31:0] mem [64];
    int          passed = 0;
    int          total = 0;
    int          lat [16];
    logic [31:0] pcr [16];
    logic        illr [16];
    int          stall_bad;

`ifdef CPU_MC_ITER_MUL_EN
    localparam int MUL_LAT = 36;
`else
    localparam int MUL_LAT = 4;
`endif

    always #5 clk = ~clk;

    assign imem_ack = imem_req & ack_en;
    assign instr    = mem[imem_addr[7:2]];

    cpu_multicycle #(.XLEN(32), .NREGS(32), .PC_RESET(32'h0)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_instr_i (instr),
        .retire_o     (retire),
        .illegal_o    (illegal),
        .pc_o         (pc),
        .dbg_raddr_i  (dbg_raddr),
        .dbg_rdata_o  (dbg_rdata)
    );

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    task automatic rd_reg(input int a, output logic [31:0] v);
        dbg_raddr = a[4:0];
        #1;
        v = dbg_rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        ack_en = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs n instructions from IDLE, optionally stalling the fetch at s_addr for s_n cycles.
    task automatic run_prog(input int n, input logic [31:0] s_addr, input int s_n);
        int cnt, k, stall_left;
        bit stall_done;
        for (int i = 0; i < 16; i++) begin
            lat[i] = -1; pcr[i] = 32'hDEADBEEF; illr[i] = 1'b0;
        end
        stall_bad = 0; cnt = 0; k = 0; stall_left = 0; stall_done = 0;
        start = 1'b1;
        while (k < n && cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (retire) begin
                lat[k] = cnt; pcr[k] = pc; illr[k] = illegal;
                k++; cnt = 0;
                if (k == n) start = 1'b0;
            end
            if (stall_left > 0) begin
                if (!(imem_req === 1'b1 && imem_addr === s_addr)) stall_bad++;
                stall_left--;
                if (stall_left == 0) ack_en = 1'b1;
            end else if (!stall_done && s_n > 0 && imem_req && imem_addr == s_addr) begin
                ack_en = 1'b0; stall_left = s_n; stall_done = 1;
            end
        end
        start = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else passed++;
        total++; if (retire !== 1'b0) $display("FAIL rst_retire got %b exp 0", retire); else passed++;
        total++; if (illegal !== 1'b0) $display("FAIL rst_illegal got %b exp 0", illegal); else passed++;
        total++; if (pc !== 32'h0) $display("FAIL rst_pc got %h exp 0", pc); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", imem_addr); else passed++;
        rd_reg(1, v);
        total++; if (v !== 32'h0) $display("FAIL rst_x1 got %h exp 0", v); else passed++;
        repeat (3) @(negedge clk);
        total++; if (imem_req !== 1'b0) $display("FAIL idle_hold_req got %b exp 0", imem_req); else passed++;
    endtask

    task automatic load_basic();
        mem[0] = 32'h00500093;             // addi x1,x0,5
        mem[1] = enc_i(-3, 0, 0, 2);       // addi x2,x0,-3
        mem[2] = enc_r(0, 2, 1, 0, 3);     // add x3,x1,x2
    endtask

    task automatic test_zero_wait();
        logic [31:0] v;
        do_reset();
        load_basic();
        run_prog(3, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            total++; if (lat[i] !== 4) $display("FAIL zw_lat%0d got %0d exp 4", i, lat[i]); else passed++;
        end
        total++; if (pcr[1] !== 32'h4) $display("FAIL zw_pc_inflight got %h exp 4", pcr[1]); else passed++;
        rd_reg(3, v);
        total++; if (v !== 32'd2) $display("FAIL zw_x3 got %h exp 2", v); else passed++;
        rd_reg(1, v);
        total++; if (v !== 32'd5) $display("FAIL zw_x1 got %h exp 5", v); else passed++;
        rd_reg(2, v);
        total++; if (v !== 32'hFFFFFFFD) $display("FAIL zw_x2 got %h exp fffffffd", v); else passed++;
        total++; if (pc !== 32'd12) $display("FAIL zw_pc got %h exp c", pc); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL zw_idle_req got %b exp 0", imem_req); else passed++;
    endtask

    task automatic test_wait_states();
        logic [31:0] v;
        do_reset();
        load_basic();
        run_prog(3, 32'h4, 3);
        total++; if (lat[0] !== 4) $display("FAIL ws_lat0 got %0d exp 4", lat[0]); else passed++;
        total++; if (lat[1] !== 7) $display("FAIL ws_lat1 got %0d exp 7", lat[1]); else passed++;
        total++; if (lat[2] !== 4) $display("FAIL ws_lat2 got %0d exp 4", lat[2]); else passed++;
        total++; if (stall_bad !== 0) $display("FAIL ws_req_addr_stable got %0d bad cycles exp 0", stall_bad); else passed++;
        rd_reg(3, v);
        total++; if (v !== 32'd2) $display("FAIL ws_x3 got %h exp 2", v); else passed++;
    endtask

    task automatic test_alu();
        logic [31:0] v;
        do_reset();
        mem[0]  = enc_i(5, 0, 0, 1);
        mem[1]  = enc_i(-3, 0, 0, 2);
        mem[2]  = enc_r(32, 2, 1, 0, 4);   // sub x4,x1,x2
        mem[3]  = enc_i(32'h401, 2, 5, 5); // srai x5,x2,1
        mem[4]  = enc_i(1, 0, 0, 6);
        mem[5]  = enc_i(33, 0, 0, 7);
        mem[6]  = enc_r(0, 7, 6, 1, 8);    // sll x8,x6,x7
        mem[7]  = enc_i(7, 0, 0, 0);       // addi x0,x0,7
        mem[8]  = enc_r(0, 2, 1, 7, 9);    // and x9,x1,x2
        mem[9]  = enc_r(0, 2, 1, 4, 10);   // xor x10,x1,x2
        mem[10] = enc_i(-1, 1, 0, 11);     // addi x11,x1,-1
        run_prog(11, 32'h0, 0);
        rd_reg(4, v);
        total++; if (v !== 32'd8) $display("FAIL alu_sub got %h exp 8", v); else passed++;
        rd_reg(5, v);
        total++; if (v !== 32'hFFFFFFFE) $display("FAIL alu_srai got %h exp fffffffe", v); else passed++;
        rd_reg(8, v);
        total++; if (v !== 32'd2) $display("FAIL alu_sll33 got %h exp 2", v); else passed++;
        rd_reg(0, v);
        total++; if (v !== 32'd0) $display("FAIL alu_x0 got %h exp 0", v); else passed++;
        rd_reg(9, v);
        total++; if (v !== 32'd5) $display("FAIL alu_and got %h exp 5", v); else passed++;
        rd_reg(10, v);
        total++; if (v !== 32'hFFFFFFF8) $display("FAIL alu_xor got %h exp fffffff8", v); else passed++;
        rd_reg(11, v);
        total++; if (v !== 32'd4) $display("FAIL alu_addi_neg got %h exp 4", v); else passed++;
        total++; if (pc !== 32'd44) $display("FAIL alu_pc got %h exp 2c", pc); else passed++;
    endtask

    task automatic test_mul();
        logic [31:0] v;
        do_reset();
        mem[0] = enc_i(99, 0, 0, 4);
        mem[1] = enc_i(1, 0, 0, 1);
        mem[2] = enc_i(16, 0, 0, 2);
        mem[3] = enc_r(0, 2, 1, 1, 3);     // sll x3,x1,x2 = 0x10000
        mem[4] = enc_r(1, 3, 3, 0, 4);     // mul x4,x3,x3
        mem[5] = enc_i(-7, 0, 0, 5);
        mem[6] = enc_i(3, 0, 0, 6);
        mem[7] = enc_r(1, 6, 5, 0, 7);     // mul x7,x5,x6
        mem[8] = enc_r(1, 6, 3, 0, 8);     // mul x8,x3,x6
        run_prog(9, 32'h0, 0);
        total++; if (lat[4] !== MUL_LAT) $display("FAIL mul_lat got %0d exp %0d", lat[4], MUL_LAT); else passed++;
        total++; if (lat[3] !== 4) $display("FAIL mul_sll_lat got %0d exp 4", lat[3]); else passed++;
        rd_reg(3, v);
        total++; if (v !== 32'h00010000) $display("FAIL mul_x3 got %h exp 00010000", v); else passed++;
        rd_reg(4, v);
        total++; if (v !== 32'h0) $display("FAIL mul_wrap got %h exp 0", v); else passed++;
        rd_reg(7, v);
        total++; if (v !== 32'hFFFFFFEB) $display("FAIL mul_neg got %h exp ffffffeb", v); else passed++;
        rd_reg(8, v);
        total++; if (v !== 32'h00030000) $display("FAIL mul_x8 got %h exp 00030000", v); else passed++;
    endtask

    task automatic test_illegal();
        logic [31:0] v;
        do_reset();
        mem[0] = enc_i(5, 0, 0, 1);
        mem[1] = 32'hFFFFFFFF;
        mem[2] = enc_r(32, 2, 1, 7, 12);   // and with funct7=0100000: not in the subset
        mem[3] = enc_i(1, 0, 0, 2);
        run_prog(4, 32'h0, 0);
        total++; if (illr[0] !== 1'b0) $display("FAIL ill_flag0 got %b exp 0", illr[0]); else passed++;
        total++; if (illr[1] !== 1'b1) $display("FAIL ill_flag1 got %b exp 1", illr[1]); else passed++;
        total++; if (illr[2] !== 1'b1) $display("FAIL ill_flag2 got %b exp 1", illr[2]); else passed++;
        total++; if (illr[3] !== 1'b0) $display("FAIL ill_flag3 got %b exp 0", illr[3]); else passed++;
        total++; if (pcr[1] !== 32'h4) $display("FAIL ill_pc got %h exp 4", pcr[1]); else passed++;
        total++; if (lat[1] !== 4) $display("FAIL ill_lat got %0d exp 4", lat[1]); else passed++;
        rd_reg(31, v);
        total++; if (v !== 32'h0) $display("FAIL ill_x31 got %h exp 0", v); else passed++;
        rd_reg(12, v);
        total++; if (v !== 32'h0) $display("FAIL ill_x12 got %h exp 0", v); else passed++;
        rd_reg(1, v);
        total++; if (v !== 32'd5) $display("FAIL ill_x1 got %h exp 5", v); else passed++;
        rd_reg(2, v);
        total++; if (v !== 32'd1) $display("FAIL ill_x2 got %h exp 1", v); else passed++;
        total++; if (pc !== 32'd16) $display("FAIL ill_pc_end got %h exp 10", pc); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int cnt, seen;
        do_reset();
        mem[0] = enc_i(5, 0, 0, 1);
        mem[1] = enc_r(0, 1, 1, 0, 6);     // add x6,x1,x1
        start = 1'b1;
        cnt = 0;
        while (retire !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        total++; if (cnt !== 4) $display("FAIL rm_first_retire got %0d cycles exp 4", cnt); else passed++;
        repeat (3) @(negedge clk);        // FETCH, DECODE, EXEC of the add
        rst = 1'b1;
        start = 1'b0;
        seen = 0;
        #1;
        total++; if (pc !== 32'h0) $display("FAIL rm_pc_async got %h exp 0", pc); else passed++;
        repeat (2) begin
            @(negedge clk);
            if (retire) seen++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (retire) seen++;
        end
        total++; if (seen !== 0) $display("FAIL rm_no_retire got %0d exp 0", seen); else passed++;
        rd_reg(6, v);
        total++; if (v !== 32'h0) $display("FAIL rm_x6 got %h exp 0", v); else passed++;
        total++; if (pc !== 32'h0) $display("FAIL rm_pc got %h exp 0", pc); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL rm_req got %b exp 0", imem_req); else passed++;
    endtask

    task automatic test_start_drop();
        logic [31:0] v;
        int cnt;
        do_reset();
        mem[0] = enc_i(9, 0, 0, 1);
        mem[1] = enc_i(4, 0, 0, 2);
        start = 1'b1;
        @(negedge clk);
        total++; if (imem_req !== 1'b1) $display("FAIL sd_req_fetch got %b exp 1", imem_req); else passed++;
        @(negedge clk);                   // DECODE
        start = 1'b0;
        cnt = 0;
        while (retire !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        total++; if (cnt !== 2) $display("FAIL sd_retire got %0d cycles exp 2", cnt); else passed++;
        @(negedge clk);
        total++; if (imem_req !== 1'b0) $display("FAIL sd_idle_req got %b exp 0", imem_req); else passed++;
        total++; if (pc !== 32'h4) $display("FAIL sd_pc got %h exp 4", pc); else passed++;
        rd_reg(1, v);
        total++; if (v !== 32'd9) $display("FAIL sd_x1 got %h exp 9", v); else passed++;
        repeat (3) @(negedge clk);
        rd_reg(2, v);
        total++; if (v !== 32'h0) $display("FAIL sd_x2 got %h exp 0", v); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL sd_stay_idle got %b exp 0", imem_req); else passed++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_alu();
        test_mul();
        test_illegal();
        test_reset_mid();
        test_start_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
